// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (slave-wait timeout).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    // Read data returned to a master whose access was aborted by timeout.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Native picorv32-style memory port: valid/ready handshake, 32-bit address
// and data, 4-bit write strobe (0 = read).
interface mem_arbiter_if;

    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    // Side that issues requests.
    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    // Side that services requests.
    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/mem_arb_timeout.sv
// Slave-wait watchdog for mem_arbiter. Only instantiated when
// MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic done,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Count busy cycles without completion; saturate at the limit.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt <= '0;
        end else if (busy && !done && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expiry is only meaningful while a transaction is outstanding.
    always_comb begin
        expired = busy && (cnt == LIMIT);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto a single native memory port.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (abort slave waits longer than
// TIMEOUT_CYCLES, return TIMEOUT_RDATA, and latch err/err_addr).
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic          err,
    output logic [31:0]   err_addr
);

    import mem_arb_pkg::*;

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last;
    logic       expired;
    logic       done;
    logic       start;

    // Handshake decode shared by the FSM and the watchdog.
    always_comb begin
        done  = (state != IDLE) && (s.ready || expired);
        start = (state == IDLE) && (m0.valid || m1.valid);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (state != IDLE),
        .done    (s.ready),
        .expired (expired)
    );

    // Sticky error flag; address is captured on the first timeout only.
    // A same-cycle s_ready wins over expiry and is a normal completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (expired && !s.ready) begin
            err <= 1'b1;
            if (!err) begin
                err_addr <= s.addr;
            end
        end
    end
`else
    // No watchdog: transactions wait for the slave indefinitely.
    always_comb begin
        expired  = 1'b0;
        err      = 1'b0;
        err_addr = '0;
    end

    // TIMEOUT_CYCLES has no effect in this build.
    if (TIMEOUT_CYCLES > 0) begin : g_timeout_param_unused
    end
`endif

    // State register and round-robin pointer; m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (done) begin
                last <= (state == BUSY1);
            end
        end
    end

    // Next-state: grant from IDLE, return to IDLE on completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0.valid && (!m1.valid || last)) begin
                    state_nxt = BUSY0;
                end else if (m1.valid) begin
                    state_nxt = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (s.ready || expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: forward the granted master, route completion back to it.
    always_comb begin
        s.valid = (state != IDLE);
        if (state == BUSY1) begin
            s.addr  = m1.addr;
            s.wdata = m1.wdata;
            s.wstrb = m1.wstrb;
        end else begin
            s.addr  = m0.addr;
            s.wdata = m0.wdata;
            s.wstrb = m0.wstrb;
        end
        m0.ready = (state == BUSY0) && (s.ready || expired);
        m1.ready = (state == BUSY1) && (s.ready || expired);
        m0.rdata = (expired && !s.ready) ? TIMEOUT_RDATA : s.rdata;
        m1.rdata = (expired && !s.ready) ? TIMEOUT_RDATA : s.rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Honours MEM_ARB_TIMEOUT_EN when
// defined (timeout scenario), otherwise runs the indefinite-wait scenario.
module tb_mem_arbiter;

    localparam int unsigned TMO = 4;
    localparam logic [31:0] DEAD = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        err;
    logic [31:0] err_addr;

    mem_arbiter_if m0_bus ();
    mem_arbiter_if m1_bus ();
    mem_arbiter_if s_bus ();

    mem_arbiter #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus),
        .err      (err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: which master owns the slave (-1 none), who was served
    // last, how long the current owner has waited, and the error record.
    int          owner;
    int          last_srv;
    int unsigned waited;
    logic        merr;
    logic [31:0] merr_addr;
    logic        exp_r0, exp_r1;

    // DUT observations taken at the falling edge
    logic        obs_sv, obs_r0, obs_r1, obs_err;
    logic [31:0] obs_saddr, obs_rd0, obs_rd1, obs_erraddr;
    int          dut_grants[$];

    task automatic model_reset();
        owner     = -1;
        last_srv  = 1;
        waited    = 0;
        merr      = 1'b0;
        merr_addr = '0;
    endtask

    // One clock: compare outputs against the model, then advance the model.
    task automatic step();
        bit          expd;
        logic [31:0] exp_rd;
        logic [31:0] gaddr, gwdata;
        logic [3:0]  gwstrb;
        @(negedge clk);
        obs_sv      = s_bus.valid;
        obs_saddr   = s_bus.addr;
        obs_r0      = m0_bus.ready;
        obs_r1      = m1_bus.ready;
        obs_rd0     = m0_bus.rdata;
        obs_rd1     = m1_bus.rdata;
        obs_err     = err;
        obs_erraddr = err_addr;
        expd = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        expd = (owner >= 0) && (waited == TMO);
`endif
        exp_r0 = (owner == 0) && (s_bus.ready || expd);
        exp_r1 = (owner == 1) && (s_bus.ready || expd);
        exp_rd = (expd && !s_bus.ready) ? DEAD : s_bus.rdata;
        gaddr  = (owner == 1) ? m1_bus.addr  : m0_bus.addr;
        gwdata = (owner == 1) ? m1_bus.wdata : m0_bus.wdata;
        gwstrb = (owner == 1) ? m1_bus.wstrb : m0_bus.wstrb;

        check("s_valid", obs_sv, owner >= 0);
        if (owner >= 0) begin
            check("s_addr", obs_saddr, gaddr);
            check("s_wdata", s_bus.wdata, gwdata);
            check("s_wstrb", s_bus.wstrb, gwstrb);
        end
        check("m0_ready", obs_r0, exp_r0);
        check("m1_ready", obs_r1, exp_r1);
        if (exp_r0) check("m0_rdata", obs_rd0, exp_rd);
        if (exp_r1) check("m1_rdata", obs_rd1, exp_rd);
        check("err", obs_err, merr);
        check("err_addr", obs_erraddr, merr_addr);

        if (obs_r0) dut_grants.push_back(0);
        if (obs_r1) dut_grants.push_back(1);

        if (rst) begin
            model_reset();
        end else if (owner < 0) begin
            waited = 0;
            if (m0_bus.valid && m1_bus.valid) owner = 1 - last_srv;
            else if (m0_bus.valid)            owner = 0;
            else if (m1_bus.valid)            owner = 1;
        end else if (s_bus.ready || expd) begin
            if (expd && !s_bus.ready) begin
                if (!merr) merr_addr = gaddr;
                merr = 1'b1;
            end
            last_srv = owner;
            owner    = -1;
        end else begin
            waited++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned mcount;
        rst = 1'b1;
        m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        s_bus.ready  = 1'b0; s_bus.rdata = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state
        step();
        step();
        check("reset_s_valid", obs_sv, 1'b0);
        check("reset_err", obs_err, 1'b0);
        rst = 1'b0;

        // Single m0 request, zero-wait slave
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0002_0000; m0_bus.wdata = 32'hA5A5_0001;
        s_bus.ready = 1'b1; s_bus.rdata = 32'h0BAD_F00D;
        step();
        check("t1_idle_s_valid", obs_sv, 1'b0);
        step();
        check("t1_s_valid", obs_sv, 1'b1);
        check("t1_s_addr", obs_saddr, 32'h0002_0000);
        check("t1_m0_ready", obs_r0, 1'b1);
        check("t1_m1_ready", obs_r1, 1'b0);
        check("t1_m0_rdata", obs_rd0, 32'h0BAD_F00D);
        m0_bus.valid = 1'b0;
        step();

        // Both masters requesting continuously
        dut_grants.delete();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_1000;
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_2000; m1_bus.wstrb = 4'hF;
        for (int i = 0; i < 8; i++) step();
        check("t2_grant_count", dut_grants.size(), 4);
        for (int i = 1; i < dut_grants.size(); i++)
            check("t2_alternate", dut_grants[i] != dut_grants[i-1], 1'b1);
        m0_bus.valid = 1'b0; m1_bus.valid = 1'b0; m1_bus.wstrb = '0;
        step();

        // m1 read with three slave wait cycles
        dut_grants.delete();
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_0100;
        s_bus.ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        s_bus.ready = 1'b1; s_bus.rdata = 32'h1234_5678;
        step();
        check("t3_m1_ready", obs_r1, 1'b1);
        check("t3_m1_rdata", obs_rd1, 32'h1234_5678);
        check("t3_only_m1", dut_grants.size(), 1);
        m1_bus.valid = 1'b0; s_bus.ready = 1'b0;
        step();

        // Reset while BUSY1, then a tie goes to m0
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_0300;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_0400;
        s_bus.ready = 1'b1;
        step();
        check("t4_post_reset_idle", obs_sv, 1'b0);
        step();
        check("t4_m0_first", obs_r0, 1'b1);
        check("t4_addr", obs_saddr, 32'h0000_0400);
        m0_bus.valid = 1'b0; m1_bus.valid = 1'b0; s_bus.ready = 1'b0;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never answers: access is aborted after TMO wait cycles
        m0_bus.valid = 1'b1; m0_bus.addr = 32'hF000_0000;
        step();
        for (int i = 0; i < TMO; i++) step();
        step();
        check("t5_forced_ready", obs_r0, 1'b1);
        check("t5_dead_rdata", obs_rd0, DEAD);
        m0_bus.valid = 1'b0;
        step();
        check("t5_err", obs_err, 1'b1);
        check("t5_err_addr", obs_erraddr, 32'hF000_0000);
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_0040;
        s_bus.ready = 1'b1; s_bus.rdata = 32'h5555_AAAA;
        step();
        step();
        check("t5_normal_rdata", obs_rd0, 32'h5555_AAAA);
        m0_bus.valid = 1'b0; s_bus.ready = 1'b0;
        step();
        check("t5_err_sticky", obs_err, 1'b1);
`else
        // Slave never answers: arbiter waits indefinitely
        m0_bus.valid = 1'b1; m0_bus.addr = 32'hF000_0000;
        dut_grants.delete();
        for (int i = 0; i < 1000; i++) step();
        check("t5_no_ready", dut_grants.size(), 0);
        check("t5_still_busy", obs_sv, 1'b1);
        check("t5_no_err", obs_err, 1'b0);
        s_bus.ready = 1'b1;
        step();
        m0_bus.valid = 1'b0; s_bus.ready = 1'b0;
        step();
`endif

        // Randomized traffic
        mcount = 0;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            s_bus.ready = ($urandom_range(0, 2) == 0);
            s_bus.rdata = $urandom;
            step();
            if (exp_r0 || (!m0_bus.valid && $urandom_range(0, 1) == 1)) begin
                m0_bus.valid = $urandom_range(0, 1);
                m0_bus.addr  = $urandom;
                m0_bus.wdata = $urandom;
                m0_bus.wstrb = 4'($urandom_range(0, 15));
            end
            if (exp_r1 || (!m1_bus.valid && $urandom_range(0, 1) == 1)) begin
                m1_bus.valid = $urandom_range(0, 1);
                m1_bus.addr  = $urandom;
                m1_bus.wdata = $urandom;
                m1_bus.wstrb = 4'($urandom_range(0, 15));
            end
            if (exp_r0 || exp_r1) mcount++;
        end
        check("rand_some_traffic", mcount > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master round-robin arbiter sharing one native picorv32-style memory port (valid/ready, 32-bit address/data, 4-bit write strobe) between the CPU and a second bus master (loader/DMA). It sits between the `picorv32` instance's `mem_*` port and the memory/peripheral decoder. Each transaction is serialised onto the single slave port, and each completion is routed back to the requesting master.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: slave-wait limit, in cycles, before the arbiter aborts a transaction. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m0_valid`, `m1_valid`  in  1  master request; held high until the matching `mN_ready`.
- `m0_ready`, `m1_ready`  out  1  transaction complete for master N.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte write enables; 0 means read.
- `m0_rdata`, `m1_rdata`  out  32  read data.
- `s_valid`  out  1  slave request.
- `s_ready`  in  1  slave completion.
- `s_addr`, `s_wdata`, `s_wstrb`  out  32/32/4  forwarded from the granted master.
- `s_rdata`  in  32  slave read data.
- `err`  out  1  sticky flag: a timeout occurred.
- `err_addr`  out  32  address of the first timed-out access.

## Operation
- State machine: `IDLE`, `BUSY0`, `BUSY1`.
- Transitions from `IDLE`:
  - only `m0_valid` high → `BUSY0`.
  - only `m1_valid` high → `BUSY1`.
  - both high → grant the master not served last (round-robin pointer `last`).
- While in `BUSYn`, on `s_ready` → `IDLE`, and `last` ← n.
- `s_valid` = (state != `IDLE`).
- `s_addr`, `s_wdata` and `s_wstrb` are combinationally muxed from the granted master. Masters hold these fields stable while valid.
- `mN_ready` = `s_ready` AND state == `BUSYn`. The ungranted master's ready is always 0.
- `mN_rdata` = `s_rdata` for both masters, except when a timeout response is forced (see Configuration).
- Masters are never aborted by the arbiter, except by a timeout. A master deasserting valid mid-transaction is a protocol violation; the arbiter keeps `s_valid` until `s_ready`.
- Reset values:
  - state `IDLE`
  - `last` = 1, so m0 (CPU) wins the first tie
  - `s_valid` = 0
  - `m0_ready` = 0, `m1_ready` = 0
  - `err` = 0, `err_addr` = 0
- Reset mid-transaction: the arbiter returns to `IDLE` on the next edge, and `s_valid` is low in the following cycle. No completion is reported.

## Timing
- Arbitration latency: a request sampled in `IDLE` produces `s_valid` on the next cycle.
- Completion: `mN_ready` is high in the same cycle as `s_ready` (combinational path).
- The arbiter spends one mandatory `IDLE` bubble after each completion. Back-to-back requests therefore cost at minimum 2 cycles of arbitration plus the slave wait.
- Zero-wait slave (`s_ready` high in the first `BUSY` cycle): total 2 cycles from `valid` to `ready`.
- With both masters continuously requesting, grants strictly alternate: 0, 1, 0, 1, ...
- A single master requesting alone is granted every time, regardless of `last`.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to `BUSYn` and increments each `BUSY` cycle without `s_ready`.
  - When the counter reaches `TIMEOUT_CYCLES`, the arbiter asserts `mN_ready` for one cycle with `mN_rdata` = 32'hDEADBEEF, drops to `IDLE`, and updates `last`.
  - `err` is set and stays set until reset. `err_addr` captures the address on the first timeout only.
  - A `s_ready` arriving in the same cycle as expiry counts as a normal completion: real data, no error.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter is instantiated, and `BUSY` waits indefinitely.
  - `err` and `err_addr` are tied to 0.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `mem_arb_pkg`:
  - state enum (`IDLE`, `BUSY0`, `BUSY1`)
  - constant `TIMEOUT_RDATA` = 32'hDEADBEEF
- Sub-module `mem_arb_timeout`:
  - inputs: `clk`, `reset`, `start`, `busy`, `done`
  - output: `expired`
  - counter width is `$clog2(TIMEOUT_CYCLES+1)`
  - instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- After reset, raise `m0_valid` with `m0_addr`=0x20000 and `s_ready` tied high → `s_valid` one cycle later with `s_addr`=0x20000; `m0_ready` pulses in that same cycle; `m1_ready` stays 0.
- Hold both valids continuously with a zero-wait slave → grant order 0, 1, 0, 1; each completion is followed by one `IDLE` cycle.
- m1 read of 0x100 while the slave returns `s_rdata`=0x12345678 after 3 wait cycles → `m1_ready` high on cycle 4 with `m1_rdata`=0x12345678; `m0_ready` stays 0 throughout.
- Assert `reset` during `BUSY1` → next cycle state is `IDLE` with `s_valid`=0; with both valids then high, m0 is granted first.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `s_ready` held low, and an m0 access to 0xF0000000 → `m0_ready` is forced with rdata 0xDEADBEEF, `err`=1, `err_addr`=0xF0000000; a later normal access completes without clearing `err`.
- Without the macro and with `s_ready` held low for 1000 cycles → the arbiter stays in `BUSY`, with `err`=0 and no ready.
